// File: rtl/scoreboard_pkg.sv
// Shared definitions for the BCD scoreboard: action encoding and tick divider sizing.
package scoreboard_pkg;

    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_INC  = 2'd1,
        ACT_DEC  = 2'd2,
        ACT_CLR  = 2'd3
    } action_t;

    localparam int unsigned SIM_DIV = 5;

    // Terminal value of the free-running tick divider (period = result + 1 clocks).
    function automatic int unsigned div_terminal(input int unsigned clk_hz,
                                                 input int unsigned tick_hz,
                                                 input int          simulate);
        if (simulate != 0)
            return SIM_DIV - 1;
        else
            return (clk_hz / tick_hz) - 1;
    endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// One BCD digit adder/subtractor; o_cout is the carry (add) or borrow (sub) to the next digit.
module bcd_digit_addsub (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_sub,
    input  logic       i_cin,
    output logic [3:0] o_y,
    output logic       o_cout
);
    logic [4:0] w_sum;
    logic [4:0] w_diff;

    always_comb begin
        w_sum  = {1'b0, i_a} + {1'b0, i_b} + {4'b0, i_cin};
        w_diff = {1'b0, i_a} - {1'b0, i_b} - {4'b0, i_cin};
        o_y    = w_sum[3:0];
        o_cout = 1'b0;
        if (i_sub) begin
            // A negative difference shows up as bit 4 set; add ten to fold back into 0..9.
            if (w_diff[4]) begin
                o_y    = 4'(w_diff + 5'd10);
                o_cout = 1'b1;
            end else begin
                o_y    = w_diff[3:0];
            end
        end else if (w_sum > 5'd9) begin
            o_y    = 4'(w_sum - 5'd10);
            o_cout = 1'b1;
        end
    end

endmodule

// File: rtl/sseg_encoder.sv
// BCD digit to seven-segment pattern {g,f,e,d,c,b,a}, active-high.
module sseg_encoder (
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);
    always_comb begin
        case (i_digit)
            4'd0:    o_seg = 7'b0111111;
            4'd1:    o_seg = 7'b0000110;
            4'd2:    o_seg = 7'b1011011;
            4'd3:    o_seg = 7'b1001111;
            4'd4:    o_seg = 7'b1100110;
            4'd5:    o_seg = 7'b1101101;
            4'd6:    o_seg = 7'b1111101;
            4'd7:    o_seg = 7'b0000111;
            4'd8:    o_seg = 7'b1111111;
            4'd9:    o_seg = 7'b1101111;
            default: o_seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/scoreboard_nd.sv
// Multi-digit BCD scoreboard: debounced-by-tick buttons add/subtract a step, a burst of
// clear presses zeroes the score, and each digit drives a seven-segment pattern.
module scoreboard_nd
    import scoreboard_pkg::*;
#(
    parameter int NUM_DIGITS        = 3,
    parameter int CLK_INPUT_FREQ_HZ = 100_000_000,
    parameter int TICK_FREQ_HZ      = 100,
    parameter int SIMULATE          = 1,
    parameter int CLR_PRESSES       = 5,
    parameter int CLR_TIMEOUT       = 200,
    parameter int WRAP              = 0,
    parameter int SEG_POLARITY      = 1
) (
    input  logic                      clk_100MHz,
    input  logic                      reset,
    input  logic                      incr_score,
    input  logic                      decr_score,
    input  logic                      clr_score,
    input  logic [1:0]                step_sel,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [7*NUM_DIGITS-1:0]   sseg_out,
    output logic                      at_max,
    output logic                      at_zero,
    output logic                      limit_hit,
    output logic [2:0]                clr_count
);
    localparam int unsigned DIV_TC = div_terminal(CLK_INPUT_FREQ_HZ, TICK_FREQ_HZ, SIMULATE);
    localparam int TMO_W = $clog2(CLR_TIMEOUT + 1);
    localparam logic [4*NUM_DIGITS-1:0] MAXV_BCD = {NUM_DIGITS{4'h9}};

    logic [31:0]             r_div;
    logic                    w_tick;
    logic [2:0]              r_sync1, r_sync2, r_prev;
    logic [2:0]              w_edge;
    action_t                 w_act;
    logic [3:0]              w_step;
    logic [4*NUM_DIGITS-1:0] r_score, w_res, w_upd;
    logic [NUM_DIGITS:0]     w_chain;
    logic [7*NUM_DIGITS-1:0] w_seg;
    logic                    w_limit;
    logic                    r_limit;
    logic [2:0]              r_clr_cnt;
    logic [TMO_W-1:0]        r_tmo;

    assign w_tick = (r_div == DIV_TC);

    always_ff @(posedge clk_100MHz) begin
        if (reset)       r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + 32'd1;
    end

    // Bit order everywhere: {clr, decr, incr}.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= {clr_score, decr_score, incr_score};
            r_sync2 <= r_sync1;
            if (w_tick) r_prev <= r_sync2;
        end
    end

    assign w_edge = {3{w_tick}} & r_sync2 & ~r_prev;
    assign w_step = (step_sel == 2'd0) ? 4'd1 : {2'b00, step_sel};

    always_comb begin
        w_act = ACT_NONE;
        if (w_edge[2])                  w_act = ACT_CLR;
        else if (w_edge[0] ^ w_edge[1]) w_act = w_edge[0] ? ACT_INC : ACT_DEC;
    end

    assign w_chain[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_digit_addsub u_addsub (
                .i_a    (r_score[4*gi +: 4]),
                .i_b    ((gi == 0) ? w_step : 4'd0),
                .i_sub  (w_act == ACT_DEC),
                .i_cin  (w_chain[gi]),
                .o_y    (w_res[4*gi +: 4]),
                .o_cout (w_chain[gi+1])
            );
            sseg_encoder u_seg (
                .i_digit (r_score[4*gi +: 4]),
                .o_seg   (w_seg[7*gi +: 7])
            );
        end
    endgenerate

    // A carry/borrow out of the top digit means the result left 0..MAXV.
    always_comb begin
        w_upd   = w_res;
        w_limit = 1'b0;
        if (w_chain[NUM_DIGITS]) begin
            w_limit = 1'b1;
            if (WRAP == 0) w_upd = (w_act == ACT_DEC) ? '0 : MAXV_BCD;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_score   <= '0;
            r_clr_cnt <= '0;
            r_tmo     <= '0;
            r_limit   <= 1'b0;
        end else begin
            r_limit <= 1'b0;
            case (w_act)
                ACT_CLR: begin
                    r_tmo <= '0;
                    if (r_clr_cnt == 3'(CLR_PRESSES - 1)) begin
                        r_score   <= '0;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 3'd1;
                    end
                end
                ACT_INC, ACT_DEC: begin
                    r_score <= w_upd;
                    r_limit <= w_limit;
                end
                default: ;
            endcase
            // Idle ticks with a partial clear pending eventually discard it.
            if (w_tick && !w_edge[2] && (r_clr_cnt != 3'd0)) begin
                if (r_tmo == TMO_W'(CLR_TIMEOUT - 1)) begin
                    r_clr_cnt <= '0;
                    r_tmo     <= '0;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end
        end
    end

    assign bcd_out   = r_score;
    assign sseg_out  = (SEG_POLARITY != 0) ? w_seg : ~w_seg;
    assign at_max    = (r_score == MAXV_BCD);
    assign at_zero   = (r_score == '0);
    assign limit_hit = r_limit;
    assign clr_count = r_clr_cnt;

endmodule

// File: tb/tb_scoreboard_nd.sv
// Scoreboard bench: three scoreboard variants share one stimulus stream; an integer
// reference model queues expected results and a monitor compares them.
module tb_scoreboard_nd;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inc = 1'b0, dec = 1'b0, clr = 1'b0;
    logic [1:0] step = 2'd0;

    logic [7:0]  bcd0, bcd1;
    logic [11:0] bcd2;
    logic [13:0] seg0, seg1;
    logic [20:0] seg2;
    logic [2:0]  am, az, lh;
    logic [2:0]  cc0, cc1, cc2;

    always #5 clk = ~clk;

    scoreboard_nd #(.NUM_DIGITS(2), .WRAP(0), .SEG_POLARITY(1)) u0 (
        .clk_100MHz(clk), .reset(rst), .incr_score(inc), .decr_score(dec), .clr_score(clr),
        .step_sel(step), .bcd_out(bcd0), .sseg_out(seg0), .at_max(am[0]), .at_zero(az[0]),
        .limit_hit(lh[0]), .clr_count(cc0));
    scoreboard_nd #(.NUM_DIGITS(2), .WRAP(1), .SEG_POLARITY(1)) u1 (
        .clk_100MHz(clk), .reset(rst), .incr_score(inc), .decr_score(dec), .clr_score(clr),
        .step_sel(step), .bcd_out(bcd1), .sseg_out(seg1), .at_max(am[1]), .at_zero(az[1]),
        .limit_hit(lh[1]), .clr_count(cc1));
    scoreboard_nd #(.NUM_DIGITS(3), .WRAP(1), .SEG_POLARITY(0)) u2 (
        .clk_100MHz(clk), .reset(rst), .incr_score(inc), .decr_score(dec), .clr_score(clr),
        .step_sel(step), .bcd_out(bcd2), .sseg_out(seg2), .at_max(am[2]), .at_zero(az[2]),
        .limit_hit(lh[2]), .clr_count(cc2));

    localparam int MAXV  [3] = '{99, 99, 999};
    localparam int WRAPK [3] = '{0, 1, 1};
    localparam int NDIG  [3] = '{2, 2, 3};
    localparam int POLK  [3] = '{1, 1, 0};

    logic [63:0] bcd_a [3];
    logic [63:0] seg_a [3];
    logic [63:0] cc_a  [3];
    always_comb begin
        bcd_a[0] = 64'(bcd0); bcd_a[1] = 64'(bcd1); bcd_a[2] = 64'(bcd2);
        seg_a[0] = 64'(seg0); seg_a[1] = 64'(seg1); seg_a[2] = 64'(seg2);
        cc_a[0]  = 64'(cc0);  cc_a[1]  = 64'(cc1);  cc_a[2]  = 64'(cc2);
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string nm;
        int s0, s1, s2, cc, l0, l1, l2;
    } exp_t;
    exp_t q[$];

    // Reference model state: scores as plain integers.
    int m_sc [3];
    int m_lim [3];
    int m_cc = 0;
    int m_since = 0;

    int lh_cnt [3] = '{0, 0, 0};
    int lh_seen [3] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            if (lh[k]) lh_cnt[k] <= lh_cnt[k] + 1;
    end

    function automatic logic [63:0] to_bcd(input int v);
        logic [63:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            default: return 7'b1101111;
        endcase
    endfunction

    function automatic logic [63:0] exp_seg(input int v, input int n, input int pol);
        logic [63:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < n; i++) begin
            r[7*i +: 7] = (pol != 0) ? seg7(t % 10) : ~seg7(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    // act: 0 none, 1 increment, 2 decrement, 3 clear press
    task automatic model_act(input int act, input int st);
        int s, r;
        s = (st == 0) ? 1 : st;
        if (act == 3) begin
            m_cc++;
            m_since = 0;
            if (m_cc == 5) begin
                m_cc = 0;
                for (int k = 0; k < 3; k++) m_sc[k] = 0;
            end
        end else begin
            m_since++;
            if (act == 1 || act == 2) begin
                for (int k = 0; k < 3; k++) begin
                    r = (act == 1) ? m_sc[k] + s : m_sc[k] - s;
                    if (r > MAXV[k] || r < 0) begin
                        m_lim[k]++;
                        if (WRAPK[k] != 0) r = (r < 0) ? r + MAXV[k] + 1 : r - MAXV[k] - 1;
                        else               r = (r < 0) ? 0 : MAXV[k];
                    end
                    m_sc[k] = r;
                end
            end
        end
    endtask

    task automatic push_exp(input string nm);
        exp_t e;
        e.nm = nm;
        e.s0 = m_sc[0]; e.s1 = m_sc[1]; e.s2 = m_sc[2];
        e.cc = m_cc;
        e.l0 = m_lim[0]; e.l1 = m_lim[1]; e.l2 = m_lim[2];
        q.push_back(e);
        for (int k = 0; k < 3; k++) m_lim[k] = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_sc[k]  = 0;
            m_lim[k] = 0;
        end
        m_cc = 0;
        m_since = 0;
    endtask

    // Button high and low long enough for exactly one sampled rising edge.
    task automatic press(input logic pi, input logic pd, input logic pc, input int st,
                         input string nm);
        int act;
        @(negedge clk);
        step = 2'(st);
        inc = pi; dec = pd; clr = pc;
        repeat (12) @(negedge clk);
        inc = 1'b0; dec = 1'b0; clr = 1'b0;
        repeat (12) @(negedge clk);
        act = pc ? 3 : ((pi ^ pd) ? (pi ? 1 : 2) : 0);
        model_act(act, st);
        push_exp(nm);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        push_exp(nm);
    endtask

    task automatic idle_timeout(input string nm);
        repeat ((200 + 10) * 5) @(negedge clk);
        m_cc = 0;
        m_since = 0;
        push_exp(nm);
    endtask

    // Monitor: compares every queued expectation against all three DUTs.
    initial begin
        exp_t e;
        int sc, lw, got_l;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    sc = (k == 0) ? e.s0 : (k == 1) ? e.s1 : e.s2;
                    lw = (k == 0) ? e.l0 : (k == 1) ? e.l1 : e.l2;
                    got_l = lh_cnt[k] - lh_seen[k];
                    lh_seen[k] = lh_cnt[k];
                    chk($sformatf("%s.u%0d.bcd", e.nm, k), bcd_a[k], to_bcd(sc));
                    chk($sformatf("%s.u%0d.seg", e.nm, k), seg_a[k], exp_seg(sc, NDIG[k], POLK[k]));
                    chk($sformatf("%s.u%0d.at_max", e.nm, k), 64'(am[k]), 64'(sc == MAXV[k]));
                    chk($sformatf("%s.u%0d.at_zero", e.nm, k), 64'(az[k]), 64'(sc == 0));
                    chk($sformatf("%s.u%0d.limit_pulses", e.nm, k), 64'(got_l), 64'(lw));
                    chk($sformatf("%s.u%0d.clr_count", e.nm, k), cc_a[k], 64'(e.cc));
                end
            end
        end
    end

    initial begin
        int op, st, w;
        model_reset();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push_exp("reset");

        for (int i = 0; i < 3; i++) press(1, 0, 0, 2, "inc_step2");

        do_reset("reset2");
        for (int i = 0; i < 32; i++) press(1, 0, 0, 3, "climb");
        press(1, 0, 0, 2, "to98");
        press(1, 0, 0, 3, "top_limit");
        press(1, 0, 0, 1, "top_again");

        do_reset("reset3");
        press(1, 0, 0, 0, "step0_is1");
        press(0, 1, 0, 2, "bottom_limit");

        do_reset("reset4");
        for (int i = 0; i < 14; i++) press(1, 0, 0, 3, "to42");
        for (int i = 0; i < 5; i++) press(0, 0, 1, 1, $sformatf("clr%0d", i + 1));
        for (int i = 0; i < 14; i++) press(1, 0, 0, 3, "to42b");
        for (int i = 0; i < 4; i++) press(0, 0, 1, 1, "clr_partial");
        idle_timeout("clr_timeout");
        press(1, 0, 1, 2, "clr_beats_inc");
        idle_timeout("clr_timeout2");

        do_reset("reset5");
        @(negedge clk);
        step = 2'd1;
        inc = 1'b1;
        repeat (260) @(negedge clk);
        inc = 1'b0;
        repeat (12) @(negedge clk);
        model_act(1, 1);
        push_exp("held_inc");
        press(1, 1, 0, 3, "inc_and_dec");

        // Reset while the button is held: one new increment after release of reset.
        @(negedge clk);
        step = 2'd2;
        inc = 1'b1;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        inc = 1'b0;
        repeat (12) @(negedge clk);
        model_reset();
        model_act(1, 2);
        push_exp("reset_while_held");

        for (int i = 0; i < 60; i++) begin
            if (m_cc != 0 && m_since >= 25) idle_timeout("rand_timeout");
            op = $urandom_range(0, 4);
            st = $urandom_range(0, 3);
            case (op)
                0: press(1, 0, 0, st, "rand_inc");
                1: press(0, 1, 0, st, "rand_dec");
                2: press(1, 1, 0, st, "rand_both");
                3: press(0, 0, 1, st, "rand_clr");
                default: press(1, 0, 1, st, "rand_clr_inc");
            endcase
        end

        w = 0;
        while (q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
